// File: rtl/rv32i_regfile_sb.sv
// RV32I integer register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and can never be reserved.
module rv32i_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_reg,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic                stall,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_reg,
  output logic                issue_ready,
  input  logic                wb_enable,
  input  logic [AW-1:0]       wb_reg,
  input  logic [XLEN-1:0]     wb_data,
  output logic [AW:0]         busy_count
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  logic          wb_hit;
  logic          issue_fire;
  logic          set_new;
  logic          clr;
  logic [AW-1:0] idx;
  logic          fwd;

  assign wb_hit      = wb_enable && (wb_reg != '0);
  assign issue_ready = (issue_reg == '0) || !busy[issue_reg] ||
                       (wb_enable && (wb_reg == issue_reg));
  assign issue_fire  = issue_valid && issue_ready && (issue_reg != '0);
  // Count moves only on real transitions: a same-register issue+writeback
  // keeps the bit set, so it is neither a new set nor a clear.
  assign set_new     = issue_fire && !busy[issue_reg];
  assign clr         = wb_hit && busy[wb_reg] &&
                       !(issue_fire && (issue_reg == wb_reg));

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    idx     = '0;
    fwd     = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      idx = rd_reg[i*AW +: AW];
      fwd = (BYPASS != 0) && wb_hit && (wb_reg == idx);
      rd_data[i*XLEN +: XLEN] = fwd ? wb_data : regs[idx];
      rd_busy[i]              = busy[idx] && !fwd;
    end
  end

  assign stall = |rd_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wb_hit) regs[wb_reg] <= wb_data;
      if (clr) busy[wb_reg] <= 1'b0;
      if (issue_fire) busy[issue_reg] <= 1'b1;
      case ({set_new, clr})
        2'b10:   busy_count <= busy_count + ONE;
        2'b01:   busy_count <= busy_count - ONE;
        default: busy_count <= busy_count;
      endcase
    end
  end

endmodule
